// File: rtl/sync_handshake_src.sv
// Source-side controller for a toggle-handshake data crossing: accepts a word,
// loads the crossing register, toggles REQ_TOG and waits for the synchronised ACK_TOG.
module sync_handshake_src #(
  parameter int width       = 1,
  parameter int REQ_DELAY   = 1,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             sEN,
  input  logic [width-1:0] sD_IN,
  output logic             sRDY,
  output logic             CR_EN,
  output logic [width-1:0] CR_D,
  output logic             REQ_TOG,
  input  logic             ACK_TOG,
  output logic             BUSY,
  output logic             OVF,
  output logic [CNT_W-1:0] XFER_CNT,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD     = 2'd1,
    WAIT_ACK = 2'd2
  } state_t;

  localparam logic [3:0] DLY_INIT = 4'(REQ_DELAY - 1);

  state_t                 state, state_nxt;
  logic [3:0]             dly, dly_nxt;
  logic                   req_nxt;
  logic                   done;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_s;

  // Handshake: a word moves on any edge where sEN and sRDY are both high;
  // sRDY depends only on registered state, never on sEN.
  assign sRDY      = (state == IDLE);
  assign BUSY      = ~sRDY;
  assign CR_EN     = sEN & sRDY;
  assign CR_D      = sD_IN;
  assign dbg_state = state;
  assign ack_s     = ack_sync[SYNC_STAGES-1];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ack_sync <= '0;
    end else begin
      ack_sync <= {ack_sync[SYNC_STAGES-2:0], ACK_TOG};
    end
  end

  always_comb begin
    state_nxt = state;
    dly_nxt   = dly;
    req_nxt   = REQ_TOG;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (sEN) begin
          state_nxt = LOAD;
          dly_nxt   = DLY_INIT;
        end
      end
      LOAD: begin
        // The crossing register settles before the destination may look at it.
        if (dly == 4'd0) begin
          req_nxt   = ~REQ_TOG;
          state_nxt = WAIT_ACK;
        end else begin
          dly_nxt = dly - 4'd1;
        end
      end
      WAIT_ACK: begin
        if (ack_s == REQ_TOG) begin
          state_nxt = IDLE;
          done      = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      dly      <= 4'd0;
      REQ_TOG  <= 1'b0;
      OVF      <= 1'b0;
      XFER_CNT <= '0;
    end else begin
      state   <= state_nxt;
      dly     <= dly_nxt;
      REQ_TOG <= req_nxt;
      if (sEN && !sRDY) begin
        OVF <= 1'b1;
      end
      if (done) begin
        XFER_CNT <= XFER_CNT + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sync_handshake_src.sv
// Bench for sync_handshake_src: two instances (defaults, and REQ_DELAY=4/SYNC_STAGES=3/CNT_W=2)
// checked every cycle against a transfer-level model, plus directed literal pins.
module tb_sync_handshake_src;
  localparam int W = 8;
  localparam int RD[2] = '{1, 4};
  localparam int SS[2] = '{2, 3};
  localparam int CM[2] = '{256, 4};

  // clock / reset
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  logic         en[2];
  logic [W-1:0] din[2];
  logic         ack[2];
  logic         rdy[2], cr_en[2], req[2], busy[2], ovf[2];
  logic [W-1:0] crd[2];
  logic [7:0]   xfer0;
  logic [1:0]   xfer1;
  logic [1:0]   dbg0, dbg1;

  int checks = 0;
  int errors = 0;
  int mode[2];
  int dly[2];

  sync_handshake_src #(.width(W)) dut0 (
    .CLK(CLK), .RST(RST), .sEN(en[0]), .sD_IN(din[0]), .sRDY(rdy[0]), .CR_EN(cr_en[0]),
    .CR_D(crd[0]), .REQ_TOG(req[0]), .ACK_TOG(ack[0]), .BUSY(busy[0]), .OVF(ovf[0]),
    .XFER_CNT(xfer0), .dbg_state(dbg0));

  sync_handshake_src #(.width(W), .REQ_DELAY(4), .SYNC_STAGES(3), .CNT_W(2)) dut1 (
    .CLK(CLK), .RST(RST), .sEN(en[1]), .sD_IN(din[1]), .sRDY(rdy[1]), .CR_EN(cr_en[1]),
    .CR_D(crd[1]), .REQ_TOG(req[1]), .ACK_TOG(ack[1]), .BUSY(busy[1]), .OVF(ovf[1]),
    .XFER_CNT(xfer1), .dbg_state(dbg1));

  // Transfer-level model: a transfer accepted at cycle t toggles the request after
  // cycle t+R, then completes on the first later cycle whose S-cycle-old ack equals it.
  bit m_busy[2], m_req[2], m_ovf[2];
  int m_t[2], m_cnt[2], n_since[2];
  bit hist[2][16384];

  function automatic bit ack_seen(int l);
    return (n_since[l] >= SS[l]) ? hist[l][n_since[l] - SS[l]] : 1'b0;
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int l = 0; l < 2; l++) begin
        m_busy[l]  <= 1'b0;
        m_req[l]   <= 1'b0;
        m_ovf[l]   <= 1'b0;
        m_cnt[l]   <= 0;
        m_t[l]     <= 0;
        n_since[l] <= 0;
      end
    end else begin
      for (int l = 0; l < 2; l++) begin
        hist[l][n_since[l]] <= ack[l];
        n_since[l]          <= n_since[l] + 1;
        if (!m_busy[l]) begin
          if (en[l]) begin
            m_busy[l] <= 1'b1;
            m_t[l]    <= n_since[l];
          end
        end else begin
          if (en[l]) m_ovf[l] <= 1'b1;
          if (n_since[l] == m_t[l] + RD[l]) begin
            m_req[l] <= ~m_req[l];
          end else if (n_since[l] > m_t[l] + RD[l] && ack_seen(l) == m_req[l]) begin
            m_busy[l] <= 1'b0;
            m_cnt[l]  <= (m_cnt[l] + 1) % CM[l];
          end
        end
      end
    end
  end

  // scoreboard
  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int xfer_of(int l);
    return (l == 0) ? int'(xfer0) : int'(xfer1);
  endfunction

  always @(negedge CLK) begin
    for (int l = 0; l < 2; l++) begin
      check($sformatf("L%0d_srdy(state %0d)", l, (l == 0) ? dbg0 : dbg1), rdy[l], !m_busy[l]);
      check($sformatf("L%0d_busy", l), busy[l], m_busy[l]);
      check($sformatf("L%0d_cr_en", l), cr_en[l], en[l] & !m_busy[l]);
      check($sformatf("L%0d_cr_d", l), crd[l], din[l]);
      check($sformatf("L%0d_req_tog", l), req[l], m_req[l]);
      check($sformatf("L%0d_ovf", l), ovf[l], m_ovf[l]);
      check($sformatf("L%0d_xfer_cnt", l), xfer_of(l), m_cnt[l]);
    end
  end

  // driver: one clock step, then the destination emulators react to REQ_TOG
  task automatic tick();
    @(posedge CLK);
    #1;
    for (int l = 0; l < 2; l++) begin
      if (RST) begin
        ack[l] = 1'b0;
        dly[l] = -1;
      end else if (mode[l] == 1) begin
        ack[l] = req[l];
      end else if (mode[l] == 2) begin
        if (dly[l] == 0) begin
          ack[l] = req[l];
          dly[l] = -1;
        end else if (dly[l] > 0) begin
          dly[l]--;
        end else if (ack[l] != req[l]) begin
          dly[l] = $urandom_range(0, 4);
        end else if ($urandom_range(0, 63) == 0) begin
          ack[l] = ~ack[l];
        end
      end
    end
  endtask

  task automatic wait_rdy(int l, string name);
    int n = 0;
    while (!rdy[l] && n < 30) begin
      tick();
      n++;
    end
    check({name, "_ready_in_time"}, rdy[l], 1);
  endtask

  initial begin
    #1ms;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int last, n_acc;
    en = '{1'b0, 1'b0};
    din = '{8'h00, 8'h00};
    ack = '{1'b0, 1'b0};
    mode = '{0, 0};
    dly = '{-1, -1};
    repeat (3) tick();
    RST = 1'b0;
    tick();
    #1;
    check("rst_srdy", rdy[0], 1);
    check("rst_busy", busy[0], 0);
    check("rst_req", req[0], 0);
    check("rst_ovf", ovf[0], 0);
    check("rst_cnt", xfer0, 0);
    check("rst_cr_en", cr_en[0], 0);

    // defaults: accept 0xA5 in cycle 0, ack toggles before edge 5, idle again in cycle 7
    en[0] = 1'b1; din[0] = 8'hA5;
    #1;
    check("acc_cr_en", cr_en[0], 1);
    check("acc_cr_d", crd[0], 8'hA5);
    tick(); en[0] = 1'b0; #1;
    check("c1_busy", busy[0], 1);
    tick(); #1;
    check("c2_req", req[0], 1);
    tick();
    tick(); ack[0] = 1'b1;
    tick();
    tick(); #1;
    check("c6_srdy", rdy[0], 0);
    tick(); #1;
    check("c7_srdy", rdy[0], 1);
    check("c7_cnt", xfer0, 1);

    // REQ_DELAY=4: sEN held high through LOAD never loads, request visible in cycle 5
    en[1] = 1'b1; din[1] = 8'h5A;
    #1;
    check("d4_acc", cr_en[1], 1);
    for (int i = 1; i <= 4; i++) begin
      tick(); #1;
      check($sformatf("d4_c%0d_cr_en", i), cr_en[1], 0);
      check($sformatf("d4_c%0d_req", i), req[1], 0);
    end
    tick(); en[1] = 1'b0; #1;
    check("d4_c5_req", req[1], 1);
    check("d4_ovf", ovf[1], 1);
    ack[1] = 1'b1;
    wait_rdy(1, "d4");
    check("d4_cnt", xfer1, 1);

    // overflow: sEN pulsed during WAIT_ACK is ignored but flagged, flag is sticky
    en[0] = 1'b1; din[0] = 8'h3C;
    tick(); en[0] = 1'b0;
    tick();
    tick(); en[0] = 1'b1; din[0] = 8'hFF; #1;
    check("ovf_no_load", cr_en[0], 0);
    tick(); en[0] = 1'b0; #1;
    check("ovf_set", ovf[0], 1);
    ack[0] = 1'b0;
    wait_rdy(0, "ovf");
    check("ovf_sticky", ovf[0], 1);
    check("ovf_cnt", xfer0, 2);

    // asynchronous reset while waiting for ack with REQ_TOG=1
    en[0] = 1'b1; din[0] = 8'h77;
    tick(); en[0] = 1'b0;
    tick();
    tick(); #2;
    RST = 1'b1;
    #1;
    check("arst_req", req[0], 0);
    check("arst_srdy", rdy[0], 1);
    check("arst_cnt", xfer0, 0);
    check("arst_ovf", ovf[0], 0);
    check("arst_cnt1", xfer1, 0);
    tick();
    RST = 1'b0;
    tick(); tick();
    ack[0] = 1'b1;
    repeat (6) tick();
    #1;
    check("arst_late_ack_cnt", xfer0, 0);
    check("arst_late_ack_idle", rdy[0], 1);

    // CNT_W=2 wrap with immediate echo: accepts every 4+3+2 cycles, count 1,2,3,0
    mode[1] = 1;
    en[1] = 1'b1;
    #1;
    last = 0;
    n_acc = 0;
    for (int i = 0; i < 80 && n_acc < 5; i++) begin
      if (cr_en[1]) begin
        if (n_acc > 0) begin
          check($sformatf("wrap_period_%0d", n_acc), i - last, 9);
          check($sformatf("wrap_cnt_%0d", n_acc), xfer1, n_acc % 4);
        end
        last = i;
        n_acc++;
      end
      tick();
      #1;
    end
    check("wrap_accepts", n_acc, 5);
    en[1] = 1'b0;

    // randomized traffic with a randomly delayed destination on both instances
    mode = '{2, 2};
    for (int i = 0; i < 1500; i++) begin
      tick();
      for (int l = 0; l < 2; l++) begin
        en[l] = ($urandom_range(0, 2) == 0);
        din[l] = W'($urandom_range(0, 255));
      end
      if (i == 700) begin
        #1 RST = 1'b1;
      end
      if (i == 702) RST = 1'b0;
    end
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
